flags_commit: RTL and testbench
===============================

# flags_commit

Commit end of the execute-stage ALU interface. Accepts each `alu32` result and its freshly computed flags, merges the flags into the architectural EFLAGS register under a per-op update mask, and returns the committed EFLAGS to execute for the next operation. Results are held in a 2-entry buffer and presented to writeback over a valid/ready handshake.

## Interface
Parameters:
- `DEPTH`, 2: result buffer entries. Only 2 is supported.
- `EFLAGS_RST`, 32'h0000_0002: EFLAGS reset value. Bit 1 is reserved-one.

Ports:
- `CLK`  in  1  clock
- `CLR`  in  1  reset, synchronous, active-high
- `ex_valid`  in  1  execute presents an op
- `ex_ready`  out  1  block can accept
- `ex_op`  in  3  alu32 op code: 0 ADD, 1 OR, 2 NOT, 3 DAA, 4 AND, 5 CLD, 6 SUB (b-a), 7 STD
- `ex_result`  in  32  `alu_out`
- `ex_flags`  in  32  flags computed by alu32
- `ex_dest`  in  3  destination GPR
- `ex_wr_reg`  in  1  op writes a GPR
- `wb_valid`  out  1  buffered result available
- `wb_ready`  in  1  writeback accepts
- `wb_result`  out  32  buffered result
- `wb_dest`  out  3  buffered destination
- `wb_wr_reg`  out  1  buffered write enable
- `eflags`  out  32  committed EFLAGS, fed back to execute

## Operation
- Flag bits: OF=11, DF=10, SF=7, ZF=6, AF=4, PF=2, CF=0. Bit 1 is always 1. All other bits are always 0.
- Commit happens on accept (`ex_valid && ex_ready`). On that edge, `eflags <= (eflags & ~mask) | (ex_flags & mask)`, except for CLD and STD.
- Update mask per op:
  - ADD, SUB: OF, SF, ZF, AF, PF, CF.
  - OR, AND: OF, SF, ZF, PF, CF. The incoming OF and CF are written as given (alu32 produces 0). AF is unchanged.
  - NOT: no flags.
  - DAA: SF, ZF, AF, PF, CF. OF is unchanged.
  - CLD: DF is forced to 0. `ex_flags` is ignored.
  - STD: DF is forced to 1. `ex_flags` is ignored.
- Buffer write: on accept, the entry `{ex_result, ex_dest, ex_wr_reg & (op != CLD) & (op != STD)}` is pushed.
  - CLD and STD still occupy a slot, so retire order is preserved.
- Pop: the head entry is removed when `wb_valid && wb_ready`.
- Buffer state: `count` is 0, 1 or 2.
  - `wb_valid = (count != 0)`.
  - `ex_ready = (count != 2)`. It depends only on registered state and never on `wb_ready`.
- Push and pop in the same cycle at count 1: count stays 1 and the head advances to the new entry.
- Push and pop in the same cycle at count 2: cannot occur, because `ex_ready` is 0.
- Pointer wrap: read and write pointers are 1 bit each and wrap from 1 to 0.
- `wb_*` outputs are driven from the head entry and remain stable while `wb_valid && !wb_ready`.

## Timing
- Reset values: `eflags = EFLAGS_RST`, `count = 0`, `wb_valid = 0`, `ex_ready = 1`.
  - `wb_result`, `wb_dest` and `wb_wr_reg` are 0.
- `CLR` asserted mid-operation flushes both entries and restores EFLAGS on the same edge, regardless of `ex_valid` or `wb_ready`.
- Latency from accept to `wb_valid` is 1 cycle.
- Latency from accept to updated `eflags` is 1 cycle, registered. The exception is when the configured bypass is enabled.
- Sustained throughput is 1 op/cycle while `wb_ready` stays high.
- With `wb_ready` held low, `ex_ready` drops after 2 accepts.

## Configuration
- `FLAGS_COMMIT_BYPASS_EN`
  - Defined: `eflags` shows the merged value combinationally in the accept cycle. Back-to-back dependent ops (for example ADD then DAA) see the new flags with no bubble. The registered value still updates on the edge.
  - Undefined: `eflags` is the register only. Execute must insert one bubble between flag-dependent ops.

## Structure
- Shared package `exec_pkg`:
  - op enum `alu32_op_e`.
  - flag bit-index localparams (`FLAG_OF` … `FLAG_CF`).
  - `EFLAGS_RST`.
  - function `flag_mask(op)`.
- One sub-module, `flags_skid2`: the 2-entry buffer with count, pointers and valid/ready.
- The flag merge and EFLAGS register stay in the top level.

## Test plan
- Reset: assert `CLR` -> `eflags = 32'h2`, `wb_valid = 0`, `ex_ready = 1`.
- ADD commit: `eflags = 32'h2`; accept ADD with `ex_flags = 32'h0000_0845` (OF, ZF, PF, CF) and `ex_result = 0`, `dest = 3`, `wr = 1` -> next cycle `eflags = 32'h847`, `wb_valid = 1`, `wb_result = 0`, `wb_dest = 3`, `wb_wr_reg = 1`.
- Masking: from `eflags = 32'h0000_0813` (OF, AF, CF), accept OR with `ex_flags = 32'h0000_0044` -> `eflags = 32'h56`, with AF kept and OF/CF cleared. Then accept NOT with `ex_flags = 32'hFFFF_FFFF` -> `eflags` unchanged.
- DF ops: accept STD -> bit 10 = 1 and `wb_wr_reg = 0`. Then accept CLD -> bit 10 = 0, and all other bits unchanged.
- Backpressure: `wb_ready = 0`, push A and B -> `ex_ready = 0` after the second accept. A third op held for 3 cycles is not accepted. Raise `wb_ready` -> outputs drain A then B in order with no loss, and `ex_ready` returns to 1 one cycle after the first pop.
- Reset mid-flight: count = 2 with `eflags = 32'h8C3`; assert `CLR` with `ex_valid = 1` -> `wb_valid = 0`, `eflags = 32'h2`, and no entry committed.

Source files
------------

// File: rtl/exec_pkg.sv
// Shared execute-stage definitions: alu32 op codes, EFLAGS bit positions,
// reset value, writeback entry layout and the per-op flag update mask.
package exec_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_OR  = 3'd1,
        OP_NOT = 3'd2,
        OP_DAA = 3'd3,
        OP_AND = 3'd4,
        OP_CLD = 3'd5,
        OP_SUB = 3'd6,
        OP_STD = 3'd7
    } alu32_op_e;

    localparam int FLAG_OF = 11;
    localparam int FLAG_DF = 10;
    localparam int FLAG_SF = 7;
    localparam int FLAG_ZF = 6;
    localparam int FLAG_AF = 4;
    localparam int FLAG_PF = 2;
    localparam int FLAG_CF = 0;

    localparam logic [31:0] EFLAGS_RST = 32'h0000_0002;

    typedef struct packed {
        logic [31:0] result;
        logic [2:0]  dest;
        logic        wr_reg;
    } wb_entry_t;

    // Masks only ever select defined flag bits, so a merge can never disturb
    // the reserved-one bit or set an undefined bit.
    function automatic logic [31:0] flag_mask(alu32_op_e op);
        logic [31:0] m;
        m = '0;
        case (op)
            OP_ADD, OP_SUB: begin
                m[FLAG_OF] = 1'b1; m[FLAG_SF] = 1'b1; m[FLAG_ZF] = 1'b1;
                m[FLAG_AF] = 1'b1; m[FLAG_PF] = 1'b1; m[FLAG_CF] = 1'b1;
            end
            OP_OR, OP_AND: begin
                m[FLAG_OF] = 1'b1; m[FLAG_SF] = 1'b1; m[FLAG_ZF] = 1'b1;
                m[FLAG_PF] = 1'b1; m[FLAG_CF] = 1'b1;
            end
            OP_DAA: begin
                m[FLAG_SF] = 1'b1; m[FLAG_ZF] = 1'b1; m[FLAG_AF] = 1'b1;
                m[FLAG_PF] = 1'b1; m[FLAG_CF] = 1'b1;
            end
            OP_CLD, OP_STD: m[FLAG_DF] = 1'b1;
            default: m = '0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/flags_skid2.sv
// Two-entry in-order result buffer between execute commit and writeback,
// with registered count so push readiness never depends on pop readiness.
module flags_skid2
    import exec_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      clk,
    input  logic      clr,
    input  logic      push_valid,
    output logic      push_ready,
    input  wb_entry_t push_data,
    output logic      pop_valid,
    input  logic      pop_ready,
    output wb_entry_t pop_data
);

    localparam logic [1:0] FULL = 2'(DEPTH);

    wb_entry_t  mem [2];
    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] count;
    logic       push;
    logic       pop;

    assign push_ready = (count != FULL);
    assign pop_valid  = (count != 2'd0);
    assign push       = push_valid & push_ready;
    assign pop        = pop_valid & pop_ready;
    assign pop_data   = mem[rd_ptr];

    // NOTE: the storage is reset as well so the writeback outputs read as
    // zero out of reset instead of exposing uninitialised entries.
    always_ff @(posedge clk) begin
        if (clr) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/flags_commit.sv
// Execute-stage commit: merges alu32 flags into EFLAGS and buffers results for
// writeback. Define FLAGS_COMMIT_BYPASS_EN to forward merged flags in the accept cycle.
module flags_commit
    import exec_pkg::*;
#(
    parameter int          DEPTH      = 2,
    parameter logic [31:0] EFLAGS_RST = exec_pkg::EFLAGS_RST
) (
    input  logic        CLK,
    input  logic        CLR,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic [2:0]  ex_op,
    input  logic [31:0] ex_result,
    input  logic [31:0] ex_flags,
    input  logic [2:0]  ex_dest,
    input  logic        ex_wr_reg,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [31:0] wb_result,
    output logic [2:0]  wb_dest,
    output logic        wb_wr_reg,
    output logic [31:0] eflags
);

    alu32_op_e   op;
    logic        accept;
    logic        df_op;
    logic [31:0] mask;
    logic [31:0] src_flags;
    logic [31:0] merged;
    logic [31:0] eflags_q;
    wb_entry_t   push_data;
    wb_entry_t   head;

    assign op     = alu32_op_e'(ex_op);
    assign accept = ex_valid & ex_ready;
    assign df_op  = (op == OP_CLD) || (op == OP_STD);
    assign mask   = flag_mask(op);

    // NOTE: every combinational output gets a default first so no path
    // through the case leaves it unassigned and infers a latch.
    always_comb begin
        src_flags = ex_flags;
        case (op)
            OP_CLD:  src_flags = '0;
            OP_STD:  src_flags = 32'h1 << FLAG_DF;
            default: src_flags = ex_flags;
        endcase
    end

    assign merged = (eflags_q & ~mask) | (src_flags & mask);

    always_ff @(posedge CLK) begin
        if (CLR) begin
            eflags_q <= EFLAGS_RST;
        end else if (accept) begin
            eflags_q <= merged;
        end
    end

`ifdef FLAGS_COMMIT_BYPASS_EN
    assign eflags = accept ? merged : eflags_q;
`else
    assign eflags = eflags_q;
`endif

    // DF ops keep their slot for ordering but never write a GPR.
    assign push_data = '{result: ex_result, dest: ex_dest, wr_reg: ex_wr_reg & ~df_op};

    flags_skid2 #(
        .DEPTH (DEPTH)
    ) u_skid (
        .clk        (CLK),
        .clr        (CLR),
        .push_valid (ex_valid),
        .push_ready (ex_ready),
        .push_data  (push_data),
        .pop_valid  (wb_valid),
        .pop_ready  (wb_ready),
        .pop_data   (head)
    );

    assign wb_result = head.result;
    assign wb_dest   = head.dest;
    assign wb_wr_reg = head.wr_reg;

endmodule

// File: tb/tb_flags_commit.sv
// Self-checking bench for flags_commit: vector table, scoreboard of expected
// writeback entries and a reference EFLAGS model, plus corner-case sequences.
module tb_flags_commit;

    logic        CLK = 1'b0;
    logic        CLR;
    logic        ex_valid;
    logic        ex_ready;
    logic [2:0]  ex_op;
    logic [31:0] ex_result;
    logic [31:0] ex_flags;
    logic [2:0]  ex_dest;
    logic        ex_wr_reg;
    logic        wb_valid;
    logic        wb_ready;
    logic [31:0] wb_result;
    logic [2:0]  wb_dest;
    logic        wb_wr_reg;
    logic [31:0] eflags;

    always #5 CLK = ~CLK;

    flags_commit dut (
        .CLK       (CLK),
        .CLR       (CLR),
        .ex_valid  (ex_valid),
        .ex_ready  (ex_ready),
        .ex_op     (ex_op),
        .ex_result (ex_result),
        .ex_flags  (ex_flags),
        .ex_dest   (ex_dest),
        .ex_wr_reg (ex_wr_reg),
        .wb_valid  (wb_valid),
        .wb_ready  (wb_ready),
        .wb_result (wb_result),
        .wb_dest   (wb_dest),
        .wb_wr_reg (wb_wr_reg),
        .eflags    (eflags)
    );

    typedef struct {
        logic [31:0] result;
        logic [2:0]  dest;
        logic        wr;
    } exp_t;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] flags;
        logic [31:0] result;
        logic [2:0]  dest;
        logic        wr;
        logic [31:0] exp_eflags;
    } vec_t;

    exp_t        sb[$];
    vec_t        vecs[9];
    logic [31:0] m_eflags;
    int          m_count;
    int          n_checks;
    int          n_pass;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [31:0] model_merge(input logic [31:0] cur, input logic [2:0] op,
                                                input logic [31:0] f);
        logic [31:0] m;
        case (op)
            3'd0, 3'd6: m = 32'h0000_08D5;
            3'd1, 3'd4: m = 32'h0000_08C5;
            3'd3:       m = 32'h0000_00D5;
            3'd5:       return cur & ~32'h0000_0400;
            3'd7:       return cur | 32'h0000_0400;
            default:    m = 32'h0;
        endcase
        return (cur & ~m) | (f & m);
    endfunction

    task automatic drive(input logic [2:0] op, input logic [31:0] flags, input logic [31:0] res,
                         input logic [2:0] dest, input logic wr);
        ex_valid  = 1'b1;
        ex_op     = op;
        ex_flags  = flags;
        ex_result = res;
        ex_dest   = dest;
        ex_wr_reg = wr;
    endtask

    // One clock: check handshake, head entry and combinational eflags before
    // the edge, advance the model on the edge, then check registered eflags.
    task automatic cycle();
        logic        acc;
        logic        pop;
        logic [31:0] nxt;
        exp_t        e;
        #1;
        acc = !CLR && ex_valid && (m_count != 2);
        pop = !CLR && wb_ready && (m_count != 0);
        check("ex_ready", {31'b0, ex_ready}, {31'b0, m_count != 2});
        check("wb_valid", {31'b0, wb_valid}, {31'b0, m_count != 0});
        if (m_count != 0) begin
            check("wb_result", wb_result, sb[0].result);
            check("wb_dest", {29'b0, wb_dest}, {29'b0, sb[0].dest});
            check("wb_wr_reg", {31'b0, wb_wr_reg}, {31'b0, sb[0].wr});
        end
        nxt = acc ? model_merge(m_eflags, ex_op, ex_flags) : m_eflags;
`ifdef FLAGS_COMMIT_BYPASS_EN
        check("eflags_comb", eflags, nxt);
`else
        check("eflags_comb", eflags, m_eflags);
`endif
        @(posedge CLK);
        if (CLR) begin
            m_eflags = 32'h2;
            m_count  = 0;
            sb.delete();
        end else begin
            m_eflags = nxt;
            if (pop) void'(sb.pop_front());
            if (acc) begin
                e.result = ex_result;
                e.dest   = ex_dest;
                e.wr     = ex_wr_reg && (ex_op != 3'd5) && (ex_op != 3'd7);
                sb.push_back(e);
            end
            m_count = m_count + int'(acc) - int'(pop);
        end
        #1;
        ex_valid = 1'b0;
        #1;
        check("eflags_reg", eflags, m_eflags);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        vecs[0] = '{3'd0, 32'h0000_0845, 32'h0000_0000, 3'd3, 1'b1, 32'h0000_0847};
        vecs[1] = '{3'd0, 32'h0000_0811, 32'h1234_5678, 3'd1, 1'b1, 32'h0000_0813};
        vecs[2] = '{3'd1, 32'h0000_0044, 32'h0000_00FF, 3'd2, 1'b1, 32'h0000_0056};
        vecs[3] = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_0000, 3'd4, 1'b1, 32'h0000_0056};
        vecs[4] = '{3'd7, 32'hFFFF_FFFF, 32'h0000_0007, 3'd5, 1'b1, 32'h0000_0456};
        vecs[5] = '{3'd5, 32'h0000_0000, 32'h0000_0005, 3'd6, 1'b1, 32'h0000_0056};
        vecs[6] = '{3'd3, 32'h0000_08D5, 32'h0000_0099, 3'd7, 1'b1, 32'h0000_00D7};
        vecs[7] = '{3'd6, 32'hFFFF_FFFF, 32'h8000_0001, 3'd0, 1'b0, 32'h0000_08D7};
        vecs[8] = '{3'd4, 32'h0000_0000, 32'hDEAD_BEEF, 3'd2, 1'b1, 32'h0000_0012};

        CLR = 1'b1;
        wb_ready = 1'b1;
        drive(3'd2, 32'h0, 32'h0, 3'd0, 1'b0);
        ex_valid = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        m_eflags = 32'h2;
        m_count  = 0;
        check("rst_eflags", eflags, 32'h0000_0002);
        check("rst_wb_valid", {31'b0, wb_valid}, 32'h0);
        check("rst_ex_ready", {31'b0, ex_ready}, 32'h1);
        check("rst_wb_result", wb_result, 32'h0);
        check("rst_wb_dest", {29'b0, wb_dest}, 32'h0);
        check("rst_wb_wr_reg", {31'b0, wb_wr_reg}, 32'h0);
        CLR = 1'b0;

        // Back-to-back accepts at full rate with writeback always ready.
        for (int i = 0; i < 9; i++) begin
            drive(vecs[i].op, vecs[i].flags, vecs[i].result, vecs[i].dest, vecs[i].wr);
            cycle();
            check($sformatf("vec%0d_eflags", i), eflags, vecs[i].exp_eflags);
        end
        cycle();

        // Backpressure: two accepts fill the buffer, a third op is refused.
        wb_ready = 1'b0;
        drive(3'd0, 32'h0000_08C1, 32'h0000_000A, 3'd1, 1'b1);
        cycle();
        drive(3'd2, 32'h0, 32'h0000_000B, 3'd2, 1'b1);
        cycle();
        check("bp_ex_ready_low", {31'b0, ex_ready}, 32'h0);
        for (int i = 0; i < 3; i++) begin
            drive(3'd4, 32'h0, 32'h0000_000C, 3'd3, 1'b1);
            cycle();
        end
        check("bp_held_eflags", eflags, 32'h0000_08C3);
        check("bp_head_a", wb_result, 32'h0000_000A);
        wb_ready = 1'b1;
        cycle();
        check("bp_ready_back", {31'b0, ex_ready}, 32'h1);
        check("bp_head_b", wb_result, 32'h0000_000B);
        cycle();
        cycle();
        check("bp_drained", {31'b0, wb_valid}, 32'h0);

        // Reset with the buffer full and an op offered.
        wb_ready = 1'b0;
        drive(3'd0, 32'h0000_08C1, 32'h0000_0011, 3'd1, 1'b1);
        cycle();
        drive(3'd2, 32'h0, 32'h0000_0022, 3'd2, 1'b1);
        cycle();
        check("mf_eflags_pre", eflags, 32'h0000_08C3);
        CLR = 1'b1;
        wb_ready = 1'b1;
        drive(3'd0, 32'hFFFF_FFFF, 32'h0000_0033, 3'd3, 1'b1);
        cycle();
        check("mf_wb_valid", {31'b0, wb_valid}, 32'h0);
        check("mf_eflags", eflags, 32'h0000_0002);
        CLR = 1'b0;
        cycle();
        check("mf_no_commit", {31'b0, wb_valid}, 32'h0);

        // Random traffic against the scoreboard.
        for (int i = 0; i < 60; i++) begin
            wb_ready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) != 0)
                drive(3'($urandom_range(0, 7)), $urandom(), $urandom(),
                      3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
